// File: rtl/envelope_trigger_detector.sv
// Envelope trigger detector: synchronizes and deglitches the envelope comparator,
// qualifies preamble pulses by width, then runs a fixed trigger window and a holdoff.
module envelope_trigger_detector #(
    parameter logic [15:0] FILTER_LEN  = 16'd4,
    parameter logic [15:0] MIN_LEN     = 16'd400,
    parameter logic [15:0] MAX_LEN     = 16'd600,
    parameter logic [15:0] TRIG_LEN    = 16'd60001,
    parameter logic [15:0] HOLDOFF_LEN = 16'd1000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        envelope_in,
    output logic        trigger_signal,
    output logic [15:0] pulse_length,
    output logic        pulse_valid,
    output logic        pulse_error
);

    typedef enum logic [2:0] {
        S_WAIT_LOW = 3'd0,
        S_IDLE     = 3'd1,
        S_MEASURE  = 3'd2,
        S_TRIGGER  = 3'd3,
        S_HOLDOFF  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        sync1_q, sync2_q;
    logic        env_s;
    logic        filt_q, filt_d;
    logic [15:0] fcnt_q, fcnt_d;
    logic [15:0] width_q, width_d;
    logic [15:0] tcnt_q, tcnt_d;
    logic [15:0] hcnt_q, hcnt_d;
    logic [15:0] lowcnt_q, lowcnt_d;
    logic [15:0] len_q, len_d;
    logic        valid_q, valid_d;
    logic        error_q, error_d;
    logic        trig_q, trig_d;

    assign env_s = sync2_q;

    // Glitch filter: the level flips only after FILTER_LEN consecutive disagreeing samples
    always_comb begin
        filt_d = filt_q;
        fcnt_d = 16'd0;
        if (env_s != filt_q) begin
            if ((fcnt_q + 16'd1) >= FILTER_LEN) begin
                filt_d = ~filt_q;
                fcnt_d = 16'd0;
            end else begin
                fcnt_d = fcnt_q + 16'd1;
            end
        end else begin
            fcnt_d = 16'd0;
        end
    end

    // Pulse qualification, trigger window and holdoff sequencing
    always_comb begin
        state_d  = state_q;
        width_d  = width_q;
        tcnt_d   = tcnt_q;
        hcnt_d   = hcnt_q;
        lowcnt_d = 16'd0;
        len_d    = len_q;
        valid_d  = 1'b0;
        error_d  = 1'b0;
        trig_d   = 1'b0;
        case (state_q)
            // Require a confirmed low (filter plus synchronizer depth) so a line
            // already high at reset release is never mistaken for a fresh rise.
            S_WAIT_LOW: begin
                if (!filt_q && !env_s) begin
                    if (lowcnt_q >= (FILTER_LEN + 16'd2)) begin
                        state_d = S_IDLE;
                    end else begin
                        lowcnt_d = lowcnt_q + 16'd1;
                    end
                end else begin
                    lowcnt_d = 16'd0;
                end
            end
            S_IDLE: begin
                if (filt_q) begin
                    width_d = 16'd1;
                    state_d = S_MEASURE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MEASURE: begin
                if (width_q > MAX_LEN) begin
                    error_d = 1'b1;
                    state_d = S_WAIT_LOW;
                end else if (filt_q) begin
                    width_d = width_q + 16'd1;
                end else if (width_q >= MIN_LEN) begin
                    valid_d = 1'b1;
                    trig_d  = 1'b1;
                    len_d   = width_q;
                    tcnt_d  = 16'd1;
                    state_d = S_TRIGGER;
                end else begin
                    error_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_TRIGGER: begin
                if (tcnt_q >= TRIG_LEN) begin
                    trig_d = 1'b0;
                    if (HOLDOFF_LEN == 16'd0) begin
                        state_d = S_WAIT_LOW;
                    end else begin
                        hcnt_d  = 16'd1;
                        state_d = S_HOLDOFF;
                    end
                end else begin
                    trig_d = 1'b1;
                    tcnt_d = tcnt_q + 16'd1;
                end
            end
            S_HOLDOFF: begin
                if (hcnt_q >= HOLDOFF_LEN) begin
                    state_d = S_WAIT_LOW;
                end else begin
                    hcnt_d = hcnt_q + 16'd1;
                end
            end
            default: begin
                state_d = S_WAIT_LOW;
            end
        endcase
    end

    // State, filter and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            filt_q   <= 1'b0;
            fcnt_q   <= 16'd0;
            state_q  <= S_WAIT_LOW;
            width_q  <= 16'd0;
            tcnt_q   <= 16'd0;
            hcnt_q   <= 16'd0;
            lowcnt_q <= 16'd0;
            len_q    <= 16'd0;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
            trig_q   <= 1'b0;
        end else begin
            sync1_q  <= envelope_in;
            sync2_q  <= sync1_q;
            filt_q   <= filt_d;
            fcnt_q   <= fcnt_d;
            state_q  <= state_d;
            width_q  <= width_d;
            tcnt_q   <= tcnt_d;
            hcnt_q   <= hcnt_d;
            lowcnt_q <= lowcnt_d;
            len_q    <= len_d;
            valid_q  <= valid_d;
            error_q  <= error_d;
            trig_q   <= trig_d;
        end
    end

    assign trigger_signal = trig_q;
    assign pulse_length   = len_q;
    assign pulse_valid    = valid_q;
    assign pulse_error    = error_q;

endmodule

// File: tb/tb_envelope_trigger_detector.sv
// Directed bench for envelope_trigger_detector with short trigger/holdoff windows.
module tb_envelope_trigger_detector;

    logic        clock;
    logic        reset;
    logic        envelope_in;
    logic        trigger_signal;
    logic [15:0] pulse_length;
    logic        pulse_valid;
    logic        pulse_error;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    int valid_cnt   = 0;
    int error_cnt   = 0;
    int trig_cycles = 0;
    int both_cnt    = 0;
    int misalign    = 0;
    logic trig_prev = 1'b0;

    envelope_trigger_detector #(
        .FILTER_LEN (16'd4),
        .MIN_LEN    (16'd400),
        .MAX_LEN    (16'd600),
        .TRIG_LEN   (16'd1000),
        .HOLDOFF_LEN(16'd100)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .envelope_in   (envelope_in),
        .trigger_signal(trigger_signal),
        .pulse_length  (pulse_length),
        .pulse_valid   (pulse_valid),
        .pulse_error   (pulse_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Event monitor sampled on the inactive edge
    always @(negedge clock) begin
        if (pulse_valid) valid_cnt = valid_cnt + 1;
        if (pulse_error) error_cnt = error_cnt + 1;
        if (trigger_signal) trig_cycles = trig_cycles + 1;
        if (pulse_valid && pulse_error) both_cnt = both_cnt + 1;
        if ((trigger_signal && !trig_prev && !pulse_valid) || (pulse_valid && !trigger_signal))
            misalign = misalign + 1;
        trig_prev = trigger_signal;
    end

    task automatic clear_mon();
        valid_cnt   = 0;
        error_cnt   = 0;
        trig_cycles = 0;
    endtask

    task automatic drive_pulse(input int n);
        @(posedge clock); #1 envelope_in = 1'b1;
        repeat (n) @(posedge clock);
        #1 envelope_in = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        envelope_in = 1'b0;
        repeat (3) @(negedge clock);
        vec_cnt++;
        if ({trigger_signal, pulse_valid, pulse_error} !== 3'b000 || pulse_length !== 16'd0) begin
            miss_cnt++;
            $display("FAIL reset_outputs: got trig=%b valid=%b err=%b len=%0d, want all 0",
                     trigger_signal, pulse_valid, pulse_error, pulse_length);
        end
        reset = 1'b1;
        repeat (20) @(negedge clock);
        vec_cnt++;
        if ({trigger_signal, pulse_valid, pulse_error} !== 3'b000) begin
            miss_cnt++;
            $display("FAIL post_reset_idle: got trig=%b valid=%b err=%b, want 000",
                     trigger_signal, pulse_valid, pulse_error);
        end
    endtask

    task automatic test_nominal();
        clear_mon();
        drive_pulse(500);
        repeat (6) @(posedge clock);
        @(negedge clock);
        vec_cnt++;
        if (trigger_signal !== 1'b0) begin
            miss_cnt++;
            $display("FAIL trig_early: trig=%b at fall+6, want 0", trigger_signal);
        end
        @(negedge clock);
        vec_cnt++;
        if (trigger_signal !== 1'b1 || pulse_valid !== 1'b1 || pulse_length !== 16'd500) begin
            miss_cnt++;
            $display("FAIL trig_rise: trig=%b valid=%b len=%0d at fall+7, want 1 1 500",
                     trigger_signal, pulse_valid, pulse_length);
        end
        repeat (1200) @(negedge clock);
        vec_cnt++;
        if (trig_cycles != 1000 || valid_cnt != 1 || error_cnt != 0) begin
            miss_cnt++;
            $display("FAIL nominal_counts: trig_cycles=%0d valid=%0d err=%0d, want 1000 1 0",
                     trig_cycles, valid_cnt, error_cnt);
        end
    endtask

    task automatic test_boundaries();
        int   lens [4] = '{399, 601, 400, 600};
        logic good [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            clear_mon();
            drive_pulse(lens[i]);
            repeat (1200) @(negedge clock);
            vec_cnt++;
            if (valid_cnt != (good[i] ? 1 : 0) || error_cnt != (good[i] ? 0 : 1) ||
                trig_cycles != (good[i] ? 1000 : 0)) begin
                miss_cnt++;
                $display("FAIL boundary_%0d: valid=%0d err=%0d trig_cycles=%0d, want good=%b",
                         lens[i], valid_cnt, error_cnt, trig_cycles, good[i]);
            end
            if (good[i]) begin
                vec_cnt++;
                if (pulse_length !== lens[i][15:0]) begin
                    miss_cnt++;
                    $display("FAIL boundary_len_%0d: got %0d", lens[i], pulse_length);
                end
            end
        end
    endtask

    task automatic test_glitch();
        clear_mon();
        @(posedge clock); #1 envelope_in = 1'b1;
        repeat (250) @(posedge clock);
        #1 envelope_in = 1'b0;
        repeat (3) @(posedge clock);
        #1 envelope_in = 1'b1;
        repeat (247) @(posedge clock);
        #1 envelope_in = 1'b0;
        repeat (1300) @(negedge clock);
        vec_cnt++;
        if (valid_cnt != 1 || error_cnt != 0 || pulse_length !== 16'd500) begin
            miss_cnt++;
            $display("FAIL low_glitch: valid=%0d err=%0d len=%0d, want 1 0 500",
                     valid_cnt, error_cnt, pulse_length);
        end
        clear_mon();
        drive_pulse(3);
        repeat (50) @(negedge clock);
        vec_cnt++;
        if (valid_cnt != 0 || error_cnt != 0 || trig_cycles != 0) begin
            miss_cnt++;
            $display("FAIL high_spike: valid=%0d err=%0d trig=%0d, want 0 0 0",
                     valid_cnt, error_cnt, trig_cycles);
        end
    endtask

    task automatic test_stuck_high();
        clear_mon();
        @(posedge clock); #1 envelope_in = 1'b1;
        repeat (600) @(posedge clock);
        @(negedge clock);
        vec_cnt++;
        if (error_cnt != 0) begin
            miss_cnt++;
            $display("FAIL stuck_early_err: err=%0d, want 0", error_cnt);
        end
        repeat (15) @(posedge clock);
        @(negedge clock);
        vec_cnt++;
        if (error_cnt != 1) begin
            miss_cnt++;
            $display("FAIL stuck_err: err=%0d, want 1", error_cnt);
        end
        repeat (1384) @(posedge clock);
        #1 envelope_in = 1'b0;
        repeat (50) @(negedge clock);
        vec_cnt++;
        if (error_cnt != 1 || valid_cnt != 0) begin
            miss_cnt++;
            $display("FAIL stuck_single: err=%0d valid=%0d, want 1 0", error_cnt, valid_cnt);
        end
        drive_pulse(500);
        repeat (1300) @(negedge clock);
        vec_cnt++;
        if (valid_cnt != 1 || pulse_length !== 16'd500) begin
            miss_cnt++;
            $display("FAIL stuck_recover: valid=%0d len=%0d, want 1 500", valid_cnt, pulse_length);
        end
    endtask

    task automatic test_ignore_edges();
        bit dropped = 1'b0;
        clear_mon();
        drive_pulse(500);
        repeat (100) @(posedge clock);
        drive_pulse(500);
        for (int k = 0; k < 2000; k++) begin
            @(negedge clock);
            if (!trigger_signal) begin
                dropped = 1'b1;
                break;
            end
        end
        vec_cnt++;
        if (!dropped) begin
            miss_cnt++;
            $display("FAIL trig_timeout: trig=%b still high after 2000 cycles, want 0", trigger_signal);
        end
        drive_pulse(500);
        repeat (300) @(negedge clock);
        vec_cnt++;
        if (valid_cnt != 1 || error_cnt != 0 || trig_cycles != 1000) begin
            miss_cnt++;
            $display("FAIL ignore_edges: valid=%0d err=%0d trig=%0d, want 1 0 1000",
                     valid_cnt, error_cnt, trig_cycles);
        end
        drive_pulse(450);
        repeat (20) @(negedge clock);
        vec_cnt++;
        if (valid_cnt != 2 || pulse_length !== 16'd450) begin
            miss_cnt++;
            $display("FAIL after_holdoff: valid=%0d len=%0d, want 2 450", valid_cnt, pulse_length);
        end
        repeat (1200) @(negedge clock);
    endtask

    task automatic test_reset_mid();
        clear_mon();
        drive_pulse(500);
        repeat (307) @(posedge clock);
        #3;
        envelope_in = 1'b1;
        reset = 1'b0;
        #1;
        vec_cnt++;
        if (trigger_signal !== 1'b0 || pulse_length !== 16'd0 || pulse_valid !== 1'b0) begin
            miss_cnt++;
            $display("FAIL async_reset: trig=%b len=%0d valid=%b, want 0 0 0",
                     trigger_signal, pulse_length, pulse_valid);
        end
        repeat (3) @(negedge clock);
        reset = 1'b1;
        clear_mon();
        repeat (800) @(negedge clock);
        vec_cnt++;
        if (valid_cnt != 0 || error_cnt != 0 || trig_cycles != 0) begin
            miss_cnt++;
            $display("FAIL reset_high_input: valid=%0d err=%0d trig=%0d, want 0 0 0",
                     valid_cnt, error_cnt, trig_cycles);
        end
        envelope_in = 1'b0;
        repeat (30) @(negedge clock);
        drive_pulse(420);
        repeat (20) @(negedge clock);
        vec_cnt++;
        if (valid_cnt != 1 || pulse_length !== 16'd420) begin
            miss_cnt++;
            $display("FAIL reset_recover: valid=%0d len=%0d, want 1 420", valid_cnt, pulse_length);
        end
        repeat (1200) @(negedge clock);
    endtask

    task automatic test_exclusive();
        vec_cnt++;
        if (both_cnt != 0 || misalign != 0) begin
            miss_cnt++;
            $display("FAIL strobe_align: both=%0d misaligned=%0d, want 0 0", both_cnt, misalign);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_boundaries();
        test_glitch();
        test_stuck_high();
        test_ignore_edges();
        test_reset_mid();
        test_exclusive();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

// File: doc/envelope_trigger_detector.md
Name: envelope_trigger_detector

Overview:
- Receive-side counterpart to the backscatter modulator.
- Samples the envelope-detector comparator output and filters glitches from it.
- Measures the width of each high pulse. A pulse whose width is inside a window qualifies as an excitation-packet preamble.
- A qualifying pulse produces the trigger_signal that gates the modulator for a fixed window, then a holdoff period.

Parameters:
FILTER_LEN, 4, consecutive equal synchronized samples required to change filtered level (1..15)
MIN_LEN, 16'd400, minimum accepted filtered-high width in cycles (inclusive)
MAX_LEN, 16'd600, maximum accepted filtered-high width in cycles (inclusive)
TRIG_LEN, 16'd60001, cycles trigger_signal stays high per qualified pulse
HOLDOFF_LEN, 16'd1000, cycles input is ignored after trigger window

Ports:
clock  input  1  system clock
reset  input  1  asynchronous active-low reset
envelope_in  input  1  asynchronous comparator output from envelope detector
trigger_signal  output  1  high during trigger window; drives modulator trigger
pulse_length  output  16  width of last qualified pulse, held until next qualification
pulse_valid  output  1  one-cycle strobe when a pulse qualifies
pulse_error  output  1  one-cycle strobe when a pulse is rejected (too short/too long)

Behaviour:
- Reset is asynchronous, active-low. While asserted:
  - All outputs are 0 and pulse_length = 16'd0.
  - Synchronizer flops, filtered level and all counters are 0.
  - State is WAIT_LOW.
- Synchronizer: envelope_in passes through 2 flops to give env_s.
- Glitch filter:
  - A counter runs while env_s differs from the filtered level and clears when they match.
  - The filtered level toggles on the cycle the counter reaches FILTER_LEN; the counter clears at the same time.
  - Both edges are delayed by 2+FILTER_LEN cycles, so measured width equals input width for clean pulses.
- FSM states: WAIT_LOW, IDLE, MEASURE, TRIGGER, HOLDOFF. All outputs are registered.
- WAIT_LOW: go to IDLE when filtered level = 0. This prevents measuring a pulse already high at reset or after holdoff.
- IDLE: on filtered rising edge, load width counter with 1 and go to MEASURE.
- MEASURE:
  - Width counter increments each cycle filtered level = 1.
  - If counter > MAX_LEN while still high: pulse_error = 1 for one cycle, go to WAIT_LOW.
  - On filtered falling edge with MIN_LEN <= width <= MAX_LEN:
    - Next cycle: pulse_valid = 1, pulse_length = width, trigger_signal = 1.
    - Go to TRIGGER with trigger counter = 1.
  - On filtered falling edge with width < MIN_LEN: pulse_error strobe next cycle, go to IDLE.
- TRIGGER:
  - trigger_signal = 1 for exactly TRIG_LEN consecutive cycles.
  - Then trigger_signal = 0 and go to HOLDOFF.
  - Input edges are ignored.
- HOLDOFF:
  - Input is ignored for HOLDOFF_LEN cycles, then go to WAIT_LOW.
  - HOLDOFF_LEN = 0 goes straight to WAIT_LOW.
- Arithmetic:
  - All counters are 16-bit unsigned.
  - The width counter cannot wrap because MAX_LEN < 16'hFFFF is required.
  - Comparisons are unsigned.
- pulse_valid and pulse_error are never high in the same cycle.
- trigger_signal rises in the same cycle as pulse_valid.
- Reset mid-operation (any state) immediately forces outputs low and state to WAIT_LOW, including mid-trigger. The modulator counter restarts on the next trigger.

Test Plan:
1. FILTER_LEN=4, MIN=400, MAX=600, TRIG_LEN=1000, HOLDOFF=100: 500-cycle high pulse -> pulse_valid once, pulse_length=500, trigger_signal high exactly 1000 cycles, starting 1 cycle after filtered falling edge (2+4+1 cycles after input fall).
2. Boundaries: pulses of 399 and 601 cycles -> pulse_error strobe, no trigger. Pulses of 400 and 600 -> pulse_valid with pulse_length 400 and 600.
3. Glitch rejection: 3-cycle low glitch inside a 500-cycle high pulse -> no edge detected, pulse_length=500. A 3-cycle isolated high spike from idle -> no MEASURE entry, no strobes.
4. Stuck high: input high 2000 cycles -> single pulse_error when counter passes 600. No further strobes until input goes low, then high again.
5. Edges ignored: second 500-cycle pulse during TRIGGER and another during HOLDOFF -> no pulse_valid. A pulse starting after HOLDOFF expiry with input low -> qualifies normally.
6. Reset asserted at trigger cycle 300 -> trigger_signal=0 immediately (asynchronous). After release with input high -> no measurement until input goes low first.
